// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-to-serial shifter (MSB first) with a one-word
// hold buffer so back-to-back words stream out with no idle gap.
module serial_bit_source #(
  parameter int unsigned WIDTH    = 8,
  parameter logic        IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             full_q, full_d;
  logic             bit_q, bit_d;
  logic             bv_q, bv_d;
  logic             wd_q, wd_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             accept;

  assign accept     = load_valid & ready_q;
  assign load_ready = ready_q;
  assign bit_out    = bit_q;
  assign bit_valid  = bv_q;
  assign word_done  = wd_q;
  assign busy       = busy_q;

  // Next-state: shifter/hold movement and the registered output values.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    full_d  = full_q;
    bit_d   = IDLE_BIT;
    bv_d    = 1'b0;
    wd_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sr_d    = load_data;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST) begin
          // Bit 0 is on the line: reload from hold, then from input, else stop.
          if (full_q) begin
            sr_d   = hold_q;
            cnt_d  = '0;
            full_d = 1'b0;
          end else if (accept) begin
            sr_d  = load_data;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          sr_d  = {sr_q[WIDTH-2:0], 1'b0};
          cnt_d = cnt_q + CW'(1);
          if (accept) begin
            hold_d = load_data;
            full_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == SHIFT) begin
      bit_d = sr_d[WIDTH-1];
      bv_d  = 1'b1;
      wd_d  = (cnt_d == LAST);
    end
    ready_d = ~full_d;
    busy_d  = (state_d == SHIFT) | full_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      bit_q   <= IDLE_BIT;
      bv_q    <= 1'b0;
      wd_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      bit_q   <= bit_d;
      bv_q    <= bv_d;
      wd_q    <= wd_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Testbench for serial_bit_source: directed scenarios plus random traffic,
// checked against a bit-queue model of the serial stream.
module tb_serial_bit_source;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready, bit_out, bit_valid, word_done, busy;
  logic         load_ready1, bit_out1, bit_valid1, word_done1, busy1;

  int n_pass  = 0;
  int n_total = 0;

  bit mq[$];
  bit acc;

  serial_bit_source #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .word_done  (word_done),
    .busy       (busy)
  );

  serial_bit_source #(.WIDTH(W), .IDLE_BIT(1'b1)) dut_idle1 (
    .clk        (clk),
    .rst        (rst),
    .load_valid (1'b0),
    .load_data  ({W{1'b0}}),
    .load_ready (load_ready1),
    .bit_out    (bit_out1),
    .bit_valid  (bit_valid1),
    .word_done  (word_done1),
    .busy       (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock: advance the model with the inputs sampled at the edge, then compare.
  task automatic step();
    int sz;
    bit ev;
    @(posedge clk);
    acc = 1'b0;
    if (rst) begin
      mq.delete();
    end else begin
      acc = load_valid && (mq.size() <= W);
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) for (int i = W - 1; i >= 0; i--) mq.push_back(load_data[i]);
    end
    #1;
    sz = mq.size();
    ev = (sz > 0);
    check("bit_out",    32'(bit_out),    32'(ev ? mq[0] : 1'b0));
    check("bit_valid",  32'(bit_valid),  32'(ev));
    check("word_done",  32'(word_done),  32'(ev && (sz % W == 1)));
    check("load_ready", 32'(load_ready), 32'(sz <= W));
    check("busy",       32'(busy),       32'(ev));
    check("idle1_bit",  32'(bit_out1),   32'(1));
    check("idle1_vld",  32'(bit_valid1), 32'(0));
  endtask

  task automatic drive(input bit v, input logic [W-1:0] d);
    load_valid = v;
    load_data  = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom());
  endtask

  initial begin
    int tries;
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hFF;
    step();
    step();
    check("rst_ready", 32'(load_ready), 32'(1));
    check("rst_busy",  32'(busy),       32'(0));
    rst = 1'b0;
    idle(3);

    // Single word A0.
    drive(1'b1, 8'hA0);
    idle(12);

    // Back-to-back A5 then 3C.
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h3C);
    idle(20);

    // Hold full: FF must wait until the hold buffer drains.
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    check("hold_full_ready", 32'(load_ready), 32'(0));
    tries = 0;
    do begin
      drive(1'b1, 8'hFF);
      tries++;
    end while (!acc && tries < 40);
    check("hold_accept_timeout", 32'(acc), 32'(1));
    idle(30);

    // Reload on the edge that ends bit 0.
    drive(1'b1, 8'h5A);
    idle(7);
    check("pre_reload_done", 32'(word_done), 32'(1));
    drive(1'b1, 8'h81);
    check("reload_first_bit", 32'(bit_out), 32'(1));
    check("reload_valid",     32'(bit_valid), 32'(1));
    idle(12);

    // Reset mid-word with a held word.
    drive(1'b1, 8'hF0);
    drive(1'b1, 8'h0F);
    idle(3);
    rst = 1'b1;
    drive(1'b1, 8'h99);
    rst = 1'b0;
    check("mid_rst_bit",   32'(bit_out),    32'(0));
    check("mid_rst_valid", 32'(bit_valid),  32'(0));
    check("mid_rst_busy",  32'(busy),       32'(0));
    check("mid_rst_ready", 32'(load_ready), 32'(1));
    idle(12);

    // Random traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 2) != 0), W'($urandom()));
    end
    rst = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
